// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver slice.
//   - rx_state_e     : receiver FSM state encoding
//   - DBIT_MIN/MAX   : legal data-bit range
//   - os_legal()     : legal oversample ratios (8/16/32)
//   - cnt_width()    : tick-counter width for a given oversample / stop length
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int DBIT_MIN = 5;
  localparam int DBIT_MAX = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic bit os_legal(input int os);
    return (os == 8) || (os == 16) || (os == 32);
  endfunction

  // Counter only has to reach max-1, so clog2(max) bits suffice.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so a reset never looks like a start bit.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   d     - asynchronous input
//   q     - synchronized output (2 clk latency)
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampling UART receiver with 3-sample majority voting,
// frame-error and break detection, and optional parity checking.
// Optional feature macro: UART_RX_PARITY_EN (PARITY state, parity_err port).
// Ports:
//   clk          - sole clock, rising edge
//   reset        - synchronous, active-high
//   s_tick       - oversample enable strobe (OVERSAMPLE ticks per bit)
//   rx           - asynchronous serial line, idle high
//   dout         - received word, LSB first on the line; held between frames
//   rx_done_tick - one-clk pulse when a frame completes
//   frame_err    - stop bit sampled low; valid with rx_done_tick
//   break_tick   - all data bits and stop bit low; pulses with rx_done_tick
//   parity_err   - parity mismatch; valid with rx_done_tick (macro only)
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_TICKS = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            break_tick
);

  localparam int CW = cnt_width(OVERSAMPLE, STOP_TICKS);

  // Stop sampling happens at OVERSAMPLE-1, so the stop phase must be at
  // least one full bit long.
  if (DBIT < DBIT_MIN || DBIT > DBIT_MAX || !os_legal(OVERSAMPLE) ||
      STOP_TICKS < OVERSAMPLE || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_rx_ext: illegal parameter set");
  end

  logic rx_s;

  uart_rx_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bcnt_q, bcnt_d;
  logic [DBIT-1:0] shreg_q;
  logic [1:0]      hist_q;
  logic            stop_err_q, stop_err_d;
  logic            maj;
  logic            os_end;
  logic            data_smp, stop_smp, frame_end;
`ifdef UART_RX_PARITY_EN
  logic            par_err_q;
  logic            par_smp;
`endif

  // hist_q holds the two previous tick samples, so at count OVERSAMPLE-1 the
  // vote covers counts OVERSAMPLE-3, -2 and -1.
  assign maj    = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
  assign os_end = (cnt_q == CW'(OVERSAMPLE - 1));

  // State register (reset wins over s_tick)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next-state logic; nothing moves without s_tick
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    if (s_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d = ST_START;
            cnt_d   = '0;
            bcnt_d  = '0;
          end
        end
        ST_START: begin
          if (cnt_q == CW'(OVERSAMPLE / 2 - 1)) begin
            cnt_d   = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;  // high mid-start = glitch
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (os_end) begin
            cnt_d = '0;
            if (bcnt_q == 4'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (os_end) begin
            cnt_d   = '0;
            state_d = ST_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (cnt_q == CW'(STOP_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode: sample strobes and frame completion
  always_comb begin
    data_smp   = s_tick && (state_q == ST_DATA) && os_end;
    stop_smp   = s_tick && (state_q == ST_STOP) && os_end;
    frame_end  = s_tick && (state_q == ST_STOP) && (cnt_q == CW'(STOP_TICKS - 1));
    // With a one-bit stop phase the stop sample and frame end share an edge,
    // so the flags use the bypassed value.
    stop_err_d = stop_smp ? ~maj : stop_err_q;
`ifdef UART_RX_PARITY_EN
    par_smp    = s_tick && (state_q == ST_PARITY) && os_end;
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q       <= 2'b11;
      shreg_q      <= '0;
      stop_err_q   <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      break_tick   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      if (s_tick)
        hist_q <= {hist_q[0], rx_s};
      // Shift right: after DBIT samples the first-received bit sits at [0]
      if (data_smp)
        shreg_q <= {maj, shreg_q[DBIT-1:1]};
      stop_err_q   <= stop_err_d;
      rx_done_tick <= frame_end;
      frame_err    <= frame_end & stop_err_d;
      break_tick   <= frame_end & stop_err_d & (shreg_q == '0);
      if (frame_end)
        dout <= shreg_q;
`ifdef UART_RX_PARITY_EN
      if (par_smp)
        par_err_q <= (^{shreg_q, maj}) ^ 1'(PARITY_ODD);
      parity_err <= frame_end & par_err_q;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
module tb_uart_rx_ext;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_a = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic [7:0] dout_a;
  logic [6:0] dout_b;
  logic       done_a, ferr_a, brk_a, perr_a;
  logic       done_b, ferr_b, brk_b, perr_b;

  typedef struct packed {
    logic [8:0] dout;
    logic       ferr;
    logic       brk;
    logic       perr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  // DUT A: 8 data bits, tick every other clk
  uart_rx_ext #(.DBIT(8)) u_a (
    .clk(clk), .reset(reset), .s_tick(tick_a), .rx(rx_a),
    .dout(dout_a), .rx_done_tick(done_a), .frame_err(ferr_a),
`ifdef UART_RX_PARITY_EN
    .parity_err(perr_a),
`endif
    .break_tick(brk_a)
  );

  // DUT B: 7 data bits, s_tick held high
  uart_rx_ext #(.DBIT(7)) u_b (
    .clk(clk), .reset(reset), .s_tick(1'b1), .rx(rx_b),
    .dout(dout_b), .rx_done_tick(done_b), .frame_err(ferr_b),
`ifdef UART_RX_PARITY_EN
    .parity_err(perr_b),
`endif
    .break_tick(brk_b)
  );

`ifndef UART_RX_PARITY_EN
  assign perr_a = 1'b0;
  assign perr_b = 1'b0;
`endif

  initial forever begin
    @(negedge clk);
    tick_a = ~tick_a;
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop expected frames when the DUT reports one
  always @(negedge clk) begin
    if (!reset) begin
      if (!done_a && (ferr_a || brk_a || perr_a)) begin
        n_tests++; n_fail++;
        $display("FAIL a_flags_idle: ferr=%b brk=%b perr=%b, expected 0", ferr_a, brk_a, perr_a);
      end
      if (done_a) begin
        if (q_a.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL a_unexpected_done: dout=%0h, expected no frame", dout_a);
        end else begin
          e_a = q_a.pop_front();
          check("a_dout", {1'b0, dout_a}, e_a.dout);
          check("a_frame_err", 9'(ferr_a), 9'(e_a.ferr));
          check("a_break", 9'(brk_a), 9'(e_a.brk));
`ifdef UART_RX_PARITY_EN
          check("a_parity_err", 9'(perr_a), 9'(e_a.perr));
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (!done_b && (ferr_b || brk_b || perr_b)) begin
        n_tests++; n_fail++;
        $display("FAIL b_flags_idle: ferr=%b brk=%b perr=%b, expected 0", ferr_b, brk_b, perr_b);
      end
      if (done_b) begin
        if (q_b.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected_done: dout=%0h, expected no frame", dout_b);
        end else begin
          e_b = q_b.pop_front();
          check("b_dout", {2'b0, dout_b}, e_b.dout);
          check("b_frame_err", 9'(ferr_b), 9'(e_b.ferr));
          check("b_break", 9'(brk_b), 9'(e_b.brk));
`ifdef UART_RX_PARITY_EN
          check("b_parity_err", 9'(perr_b), 9'(e_b.perr));
`endif
        end
      end
    end
  end

  // Drive a line level for n clk; called on a negedge
  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (n) @(negedge clk);
  endtask

  // One frame; a low stop bit is released after 3/4 of a bit so the
  // receiver's return to IDLE sees only a glitch start
  task automatic send(input bit sel, input logic [8:0] data, input int nbits,
                      input bit stop_v, input bit par_v, input exp_t e);
    int bt;
    bt = sel ? 16 : 32;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
    drive(sel, 1'b0, bt);
    for (int i = 0; i < nbits; i++) drive(sel, data[i], bt);
`ifdef UART_RX_PARITY_EN
    drive(sel, par_v, bt);
`else
    if (par_v) drive(sel, 1'b1, 0);
`endif
    if (stop_v) drive(sel, 1'b1, bt);
    else begin
      drive(sel, 1'b0, bt * 3 / 4);
      drive(sel, 1'b1, bt / 4);
    end
    drive(sel, 1'b1, 2 * bt);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && i < 4000) begin
      @(negedge clk);
      i++;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d/%0d frames pending, expected 0", q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dout", {1'b0, dout_a}, 9'h000);
    check("rst_done", 9'(done_a), 9'h0);
    check("rst_frame_err", 9'(ferr_a), 9'h0);
    check("rst_break", 9'(brk_a), 9'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 0xA5, good stop
    send(1'b0, 9'h0A5, 8, 1'b1, 1'b0, '{9'h0A5, 1'b0, 1'b0, 1'b0});
    drain();

    // False start: low for 4 ticks (8 clk), then back high
    drive(1'b0, 1'b0, 8);
    drive(1'b0, 1'b1, 64);
    check("false_start_idle", 9'(u_a.state_q), 9'(ST_IDLE));
    send(1'b0, 9'h03C, 8, 1'b1, 1'b0, '{9'h03C, 1'b0, 1'b0, 1'b0});

    // 0x81 with low stop: frame error only
    send(1'b0, 9'h081, 8, 1'b0, 1'b0, '{9'h081, 1'b1, 1'b0, 1'b0});
    // 0x00 with low stop: break
    send(1'b0, 9'h000, 8, 1'b0, 1'b0, '{9'h000, 1'b1, 1'b1, 1'b0});
    drain();

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x01 needs parity bit 1
    send(1'b0, 9'h001, 8, 1'b1, 1'b0, '{9'h001, 1'b0, 1'b0, 1'b1});
    send(1'b0, 9'h001, 8, 1'b1, 1'b1, '{9'h001, 1'b0, 1'b0, 1'b0});
    drain();
`endif

    // DUT B: abort a frame with reset during data bit 3
    drive(1'b1, 1'b0, 16);
    drive(1'b1, 1'b1, 16);
    drive(1'b1, 1'b0, 16);
    drive(1'b1, 1'b1, 16);
    drive(1'b1, 1'b1, 8);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b1, 32);
    send(1'b1, 9'h055, 7, 1'b1, 1'b0, '{9'h055, 1'b0, 1'b0, 1'b0});
    drain();
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
